// File: rtl/demultiplexer_bus_4_buffered_pkg.sv
// demultiplexer_bus_4_buffered_pkg: shared constants and channel state encoding
// for the buffered 1-to-4 bus demultiplexer.
//   NUM_CH      - number of output channels
//   SEL_W       - width of the channel select
//   chanState_t - per-channel fill state (doubles as the entry count)
package demultiplexer_bus_4_buffered_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } chanState_t;
endpackage

// File: rtl/demultiplexer_bus_4_buffered_if.sv
// demultiplexer_bus_4_buffered_if: producer/consumer bundle of the demultiplexer.
//   Enable, DemuxIn, Sel, InValid -> producer side inputs; InReady back to producer
//   DemuxOut[k], OutValid[k]      -> consumer k head data and valid
//   OutReady[k]                   -> consumer k takes the head this cycle
//   slave modport: the demultiplexer; master modport: the environment driving it
interface demultiplexer_bus_4_buffered_if #(
    parameter int NrOfBits = 1
);
    import demultiplexer_bus_4_buffered_pkg::*;
    logic                             Enable;
    logic [NrOfBits-1:0]              DemuxIn;
    logic [SEL_W-1:0]                 Sel;
    logic                             InValid;
    logic                             InReady;
    logic [NUM_CH-1:0][NrOfBits-1:0]  DemuxOut;
    logic [NUM_CH-1:0]                OutValid;
    logic [NUM_CH-1:0]                OutReady;
    modport slave (
        input  Enable, DemuxIn, Sel, InValid, OutReady,
        output InReady, DemuxOut, OutValid
    );
    modport master (
        output Enable, DemuxIn, Sel, InValid, OutReady,
        input  InReady, DemuxOut, OutValid
    );
endinterface

// File: rtl/demultiplexer_bus_4_buffered_fifo2.sv
// demux_chan_fifo2: two-entry channel FIFO of the buffered demultiplexer.
//   Clock, Reset (sync, active-low) - clocking and state clear
//   push, din                       - write din at the tail
//   pop                             - drop the head (caller only pops when valid)
//   head, valid, full               - head entry (zero when empty), non-empty, holds Depth entries
module demux_chan_fifo2
    import demultiplexer_bus_4_buffered_pkg::*;
#(
    parameter int NrOfBits = 1,
    parameter int Depth = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                push,
    input  logic                pop,
    input  logic [NrOfBits-1:0] din,
    output logic [NrOfBits-1:0] head,
    output logic                valid,
    output logic                full
);
    chanState_t          state;
    logic [NrOfBits-1:0] headQ;
    logic [NrOfBits-1:0] tailQ;

    // headQ is zeroed whenever the channel drains so head is all-zero while empty
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_EMPTY;
            headQ <= '0;
            tailQ <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (push) begin
                    state <= ST_ONE;
                    headQ <= din;
                end
                ST_ONE: if (push && pop) begin
                    headQ <= din;
                end else if (push) begin
                    state <= ST_TWO;
                    tailQ <= din;
                end else if (pop) begin
                    state <= ST_EMPTY;
                    headQ <= '0;
                end
                ST_TWO: if (pop) begin
                    state <= ST_ONE;
                    headQ <= tailQ;
                    tailQ <= '0;
                end
                default: begin
                    state <= ST_EMPTY;
                    headQ <= '0;
                    tailQ <= '0;
                end
            endcase
        end
    end

    assign head  = headQ;
    assign valid = state != ST_EMPTY;
    assign full  = state == chanState_t'(Depth);
endmodule

// File: rtl/demultiplexer_bus_4_buffered.sv
// demultiplexer_bus_4_buffered: 1-to-4 stream demultiplexer with a two-entry
// buffer per output so a stalled consumer only blocks traffic addressed to it.
//   Clock - rising-edge clock
//   Reset - synchronous active-low reset, clears all buffered entries
//   bus   - slave side of demultiplexer_bus_4_buffered_if (producer + 4 consumers)
module demultiplexer_bus_4_buffered
    import demultiplexer_bus_4_buffered_pkg::*;
#(
    parameter int NrOfBits = 1,
    parameter int Depth = 2
) (
    input  logic Clock,
    input  logic Reset,
    demultiplexer_bus_4_buffered_if.slave bus
);
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;

    // readiness looks only at the registered fill of the selected channel,
    // so a pop on a full channel frees space one cycle later
    assign bus.InReady = Reset & bus.Enable & ~full[bus.Sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : gChan
        assign push[k] = bus.InValid & bus.InReady & (bus.Sel == SEL_W'(k));
        assign pop[k]  = bus.OutValid[k] & bus.OutReady[k];
        demux_chan_fifo2 #(
            .NrOfBits(NrOfBits),
            .Depth(Depth)
        ) uFifo (
            .Clock(Clock),
            .Reset(Reset),
            .push(push[k]),
            .pop(pop[k]),
            .din(bus.DemuxIn),
            .head(bus.DemuxOut[k]),
            .valid(bus.OutValid[k]),
            .full(full[k])
        );
    end
endmodule

// File: tb/tb_demultiplexer_bus_4_buffered.sv
// tb_demultiplexer_bus_4_buffered: directed and random checks of the buffered
// demultiplexer against four reference queues.
module tb_demultiplexer_bus_4_buffered;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int passes = 0;
    bit modelKnown = 1'b0;
    logic [7:0] q[4][$];
    logic [3:0] holdPrev = '0;
    logic [7:0] prevOut[4];

    demultiplexer_bus_4_buffered_if #(.NrOfBits(8)) bus ();

    demultiplexer_bus_4_buffered #(.NrOfBits(8), .Depth(2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic en, input logic iv, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] ordy);
        Reset = rst;
        bus.Enable = en;
        bus.InValid = iv;
        bus.Sel = s;
        bus.DemuxIn = d;
        bus.OutReady = ordy;
    endtask

    task automatic compareModel();
        if (modelKnown) begin
            check("InReady", {31'd0, bus.InReady},
                  {31'd0, Reset && bus.Enable && q[bus.Sel].size() != 2});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("OutValid_%0d", k), {31'd0, bus.OutValid[k]}, {31'd0, q[k].size() != 0});
                check($sformatf("DemuxOut_%0d", k), {24'd0, bus.DemuxOut[k]},
                      {24'd0, (q[k].size() != 0) ? q[k][0] : 8'h00});
                if (holdPrev[k])
                    check($sformatf("hold_%0d", k), {23'd0, bus.OutValid[k], bus.DemuxOut[k]},
                          {23'd0, 1'b1, prevOut[k]});
            end
        end
    endtask

    task automatic tick();
        #1 compareModel();
        for (int k = 0; k < 4; k++) begin
            holdPrev[k] = Reset && bus.OutValid[k] && !bus.OutReady[k];
            prevOut[k] = bus.DemuxOut[k];
        end
        @(posedge Clock);
        if (!Reset) begin
            for (int k = 0; k < 4; k++) q[k].delete();
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            logic accept;
            accept = bus.InValid && bus.Enable && q[bus.Sel].size() != 2;
            for (int k = 0; k < 4; k++)
                if (q[k].size() != 0 && bus.OutReady[k]) void'(q[k].pop_front());
            if (accept) q[bus.Sel].push_back(bus.DemuxIn);
        end
        @(negedge Clock);
    endtask

    initial begin
        drive(0, 1, 0, 0, 8'h00, 4'h0);
        tick();
        tick();
        // basic route to channel 2
        drive(1, 1, 1, 2, 8'h11, 4'h0);
        tick();
        drive(1, 1, 0, 0, 8'h00, 4'h0);
        #1;
        check("t1 OutValid_2", {31'd0, bus.OutValid[2]}, 32'd1);
        check("t1 DemuxOut_2", {24'd0, bus.DemuxOut[2]}, 32'h11);
        for (int k = 0; k < 4; k++) if (k != 2) begin
            check("t1 OutValid_other", {31'd0, bus.OutValid[k]}, 32'd0);
            check("t1 DemuxOut_other", {24'd0, bus.DemuxOut[k]}, 32'd0);
        end
        drive(1, 1, 0, 0, 8'h00, 4'b0100);
        tick();
        // fill channel 1 and apply backpressure
        drive(1, 1, 1, 1, 8'hA1, 4'h0);
        tick();
        drive(1, 1, 1, 1, 8'hA2, 4'h0);
        tick();
        drive(1, 1, 1, 1, 8'hA3, 4'h0);
        #1 check("t2 InReady full", {31'd0, bus.InReady}, 32'd0);
        tick();
        drive(1, 1, 0, 3, 8'h00, 4'h0);
        #1 check("t2 InReady sel3", {31'd0, bus.InReady}, 32'd1);
        tick();
        drive(1, 1, 0, 1, 8'h00, 4'b0010);
        #1;
        check("t2 head A1", {24'd0, bus.DemuxOut[1]}, 32'hA1);
        check("t2 no ready-through", {31'd0, bus.InReady}, 32'd0);
        tick();
        #1;
        check("t2 head A2", {24'd0, bus.DemuxOut[1]}, 32'hA2);
        check("t2 InReady back", {31'd0, bus.InReady}, 32'd1);
        tick();
        drive(1, 1, 0, 0, 8'h00, 4'h0);
        #1 check("t2 drained", {31'd0, bus.OutValid[1]}, 32'd0);
        // push and pop together on a one-entry channel
        drive(1, 1, 1, 0, 8'h05, 4'h0);
        tick();
        drive(1, 1, 1, 0, 8'h06, 4'b0001);
        tick();
        drive(1, 1, 0, 0, 8'h00, 4'h0);
        #1;
        check("t3 OutValid_0", {31'd0, bus.OutValid[0]}, 32'd1);
        check("t3 DemuxOut_0", {24'd0, bus.DemuxOut[0]}, 32'h06);
        check("t3 model count", q[0].size(), 32'd1);
        drive(1, 1, 0, 0, 8'h00, 4'b0001);
        tick();
        // enable gating while channel 3 drains
        drive(1, 1, 1, 3, 8'h33, 4'h0);
        tick();
        drive(1, 0, 1, 0, 8'h77, 4'b1000);
        #1;
        check("t4 InReady disabled", {31'd0, bus.InReady}, 32'd0);
        check("t4 DemuxOut_3", {24'd0, bus.DemuxOut[3]}, 32'h33);
        tick();
        drive(1, 1, 0, 0, 8'h00, 4'h0);
        #1;
        check("t4 nothing buffered", {31'd0, bus.OutValid[0]}, 32'd0);
        check("t4 ch3 drained", {31'd0, bus.OutValid[3]}, 32'd0);
        // reset in the middle of traffic
        drive(1, 1, 1, 0, 8'h41, 4'h0);
        tick();
        drive(1, 1, 1, 0, 8'h42, 4'h0);
        tick();
        drive(1, 1, 1, 2, 8'h43, 4'h0);
        tick();
        drive(1, 1, 1, 2, 8'h44, 4'h0);
        tick();
        drive(0, 1, 0, 0, 8'h00, 4'h0);
        #1;
        check("t5 InReady in reset", {31'd0, bus.InReady}, 32'd0);
        check("t5 ch0 before edge", {31'd0, bus.OutValid[0]}, 32'd1);
        tick();
        drive(1, 1, 0, 0, 8'h00, 4'h0);
        #1;
        check("t5 InReady after", {31'd0, bus.InReady}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("t5 OutValid cleared", {31'd0, bus.OutValid[k]}, 32'd0);
            check("t5 DemuxOut cleared", {24'd0, bus.DemuxOut[k]}, 32'd0);
        end
        // random traffic
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(99) != 0, $urandom_range(9) != 0, 1'($urandom_range(1)),
                  2'($urandom_range(3)), 8'($urandom), 4'($urandom_range(15)));
            tick();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
